// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: the FSM state
// type and its fixed encodings, which also appear on the debug state port.
package counter_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl_count_core.sv
// Counter datapath for counter_seq_ctrl: a plain up-counter with a
// synchronous clear that wins over the increment enable.
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // Count register: reset and clear return to zero, enable steps by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a free-running up-counter: start/stop/pause,
// programmable period, one-shot or auto-reload mode and a registered
// terminal-count pulse. Defining COUNTER_SEQ_CTRL_PRESCALE_EN adds a
// prescaler so the counter advances once every PRESCALE cycles in RUN.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic [1:0]       state
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] period_q;
    logic             auto_q;
    logic             done_q;
    logic             tick;
    logic             start_ok;
    logic             terminal;
    logic             accept;
    logic             term_tick;
    logic             clr;
    logic             en;

    // A start with a zero period is treated as no start at all.
    assign start_ok = start && (period != '0);
    assign terminal = (count == (period_q - WIDTH'(1)));

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    assign tick = (state_q == RUN) && (pre_q == PRE_LAST);

    // Prescaler: restarts on a new run, on stop and on each tick; holds while paused.
    always_ff @(posedge clk) begin
        if (reset || accept || stop) begin
            pre_q <= '0;
        end else if ((state_q == RUN) && !pause) begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = (PRESCALE > 1);
    assign tick            = (state_q == RUN);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop beats pause, pause beats start and the tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!stop && start_ok) state_d = RUN;
            end
            RUN: begin
                if (stop)                                state_d = IDLE;
                else if (pause)                          state_d = PAUSE;
                else if (tick && terminal && !auto_q)    state_d = DONE;
            end
            PAUSE: begin
                if (stop)        state_d = IDLE;
                else if (!pause) state_d = RUN;
            end
            DONE: begin
                if (stop)          state_d = IDLE;
                else if (start_ok) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls: counter clear/enable, latch strobe and terminal tick.
    always_comb begin
        accept    = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        term_tick = 1'b0;
        case (state_q)
            IDLE: begin
                clr    = 1'b1;
                accept = !stop && start_ok;
            end
            RUN: begin
                if (stop) begin
                    clr = 1'b1;
                end else if (!pause && tick) begin
                    term_tick = terminal;
                    if (terminal && auto_q) clr = 1'b1;
                    else if (!terminal)     en  = 1'b1;
                end
            end
            PAUSE: begin
                if (stop) clr = 1'b1;
            end
            DONE: begin
                if (stop) begin
                    clr = 1'b1;
                end else if (start_ok) begin
                    accept = 1'b1;
                    clr    = 1'b1;
                end
            end
            default: clr = 1'b1;
        endcase
    end

    // Period/mode latches update only on an accepted start; done is the
    // terminal tick delayed by one cycle so it is a clean one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= '0;
            auto_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= term_tick;
            if (accept) begin
                period_q <= period;
                auto_q   <= auto_reload;
            end
        end
    end

    count_core #(
        .WIDTH (WIDTH)
    ) u_count_core (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .q     (count)
    );

    assign running = (state_q == RUN);
    assign done    = done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl. With
// COUNTER_SEQ_CTRL_PRESCALE_EN defined it runs the prescaled sequence instead
// of the single-cycle-tick sequences.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       auto_reload;
    logic [3:0] period;
    logic [3:0] count;
    logic       running;
    logic       done;
    logic [1:0] state;

    int tests_run    = 0;
    int tests_failed = 0;

    counter_seq_ctrl #(
        .WIDTH    (4),
        .PRESCALE (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .period      (period),
        .count       (count),
        .running     (running),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then let a rising edge pass and settle.
    task automatic applyStimulus(input logic s, input logic sp, input logic ps,
                                 input logic ar, input logic [3:0] per);
        start       = s;
        stop        = sp;
        pause       = ps;
        auto_reload = ar;
        period      = per;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic expectAll(input string tag, input int st, input int cnt, input int dn);
        checkOutput({tag, ".state"}, 32'(state), st);
        checkOutput({tag, ".count"}, 32'(count), cnt);
        checkOutput({tag, ".done"},  32'(done),  dn);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1; stop = 1'b0; pause = 1'b0; auto_reload = 1'b0; period = 4'd5;

        // Reset wins over a held start.
        applyStimulus(1, 0, 0, 0, 4'd5);
        applyStimulus(1, 0, 0, 0, 4'd5);
        expectAll("reset", 0, 0, 0);
        checkOutput("reset.running", 32'(running), 0);
        reset = 1'b0;

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
        // Period 2, prescale 4: count steps every 4 cycles, done 8 cycles after accept.
        applyStimulus(1, 0, 0, 0, 4'd2);
        expectAll("pre.accept", 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 0, 0, 0, 4'd2);
            if (k < 4)       expectAll($sformatf("pre.k%0d", k), 1, 0, 0);
            else if (k < 8)  expectAll($sformatf("pre.k%0d", k), 1, 1, 0);
            else             expectAll($sformatf("pre.k%0d", k), 3, 1, 1);
        end
`else
        // Start is accepted on the first edge after reset release.
        applyStimulus(1, 0, 0, 0, 4'd5);
        expectAll("os.accept", 1, 0, 0);
        checkOutput("os.running", 32'(running), 1);

        // One-shot, period 5.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 0, 4'd5);
            expectAll($sformatf("os.k%0d", k), 1, k, 0);
        end
        applyStimulus(0, 0, 0, 0, 4'd5);
        expectAll("os.term", 3, 4, 1);
        applyStimulus(0, 0, 0, 0, 4'd5);
        expectAll("os.hold", 3, 4, 0);

        // Auto-reload, period 3, restarted from DONE.
        applyStimulus(1, 0, 0, 1, 4'd3);
        expectAll("ar.accept", 1, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(0, 0, 0, 0, 4'd3);
            expectAll($sformatf("ar.k%0d", k), 1, k % 3, (k % 3 == 0) ? 1 : 0);
        end
        applyStimulus(0, 1, 0, 0, 4'd3);
        expectAll("ar.stop", 0, 0, 0);

        // Pause at count 2 with period 10.
        applyStimulus(1, 0, 0, 0, 4'd10);
        expectAll("pz.accept", 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 4'd10);
        applyStimulus(0, 0, 0, 0, 4'd10);
        expectAll("pz.pre", 1, 2, 0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 0, 1, 0, 4'd10);
            expectAll($sformatf("pz.p%0d", k), 2, 2, 0);
        end
        applyStimulus(0, 0, 0, 0, 4'd10);
        expectAll("pz.resume", 1, 2, 0);
        for (int k = 3; k <= 9; k++) begin
            applyStimulus(0, 0, 0, 0, 4'd10);
            expectAll($sformatf("pz.c%0d", k), 1, k, 0);
        end
        applyStimulus(0, 0, 0, 0, 4'd10);
        expectAll("pz.term", 3, 9, 1);
        applyStimulus(0, 1, 0, 0, 4'd10);
        expectAll("pz.stop", 0, 0, 0);

        // Zero period start is ignored.
        applyStimulus(1, 0, 0, 1, 4'd0);
        expectAll("p0.ignore", 0, 0, 0);

        // Period 1 with auto-reload: done every cycle after the first tick.
        applyStimulus(1, 0, 0, 1, 4'd1);
        expectAll("p1.accept", 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 0, 0, 4'd1);
            expectAll($sformatf("p1.k%0d", k), 1, 0, 1);
        end
        applyStimulus(0, 1, 0, 0, 4'd1);
        expectAll("p1.stop", 0, 0, 0);

        // Stop, pause and start together in RUN select IDLE.
        applyStimulus(1, 0, 0, 0, 4'd5);
        applyStimulus(0, 0, 0, 0, 4'd5);
        expectAll("all.run", 1, 1, 0);
        applyStimulus(1, 1, 1, 0, 4'd5);
        expectAll("all.idle", 0, 0, 0);

        // Period change mid-run does not move the terminal count.
        applyStimulus(1, 0, 0, 0, 4'd3);
        expectAll("pc.accept", 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'd7);
        applyStimulus(1, 0, 0, 1, 4'd7);
        expectAll("pc.k2", 1, 2, 0);
        applyStimulus(0, 0, 0, 1, 4'd7);
        expectAll("pc.term", 3, 2, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
